// File: rtl/chess_move_pkg.sv
// Move-code definitions shared by the serializer, compactor and search stages.
package chess_move_pkg;

    localparam int MOVE_W = 4;
    localparam int LANES  = 4;

    typedef logic [MOVE_W-1:0] move_t;

    localparam move_t NO_MOVE = 4'h0;

endpackage

// File: rtl/lane_compactor.sv
// Combinational lane scan: counts non-empty move lanes and gives each
// non-empty lane its packed write offset (prefix count of earlier non-empty lanes).
module lane_compactor
    import chess_move_pkg::*;
#(
    parameter int MOVE_W = chess_move_pkg::MOVE_W,
    parameter int LANES  = chess_move_pkg::LANES,
    parameter int NZ_W   = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0][MOVE_W-1:0] lanes,
    output logic [NZ_W-1:0]              nz,
    output logic [LANES-1:0][NZ_W-1:0]   offset,
    output logic [LANES-1:0]             we
);

    logic [NZ_W-1:0] run;

    always_comb begin
        run    = '0;
        offset = '0;
        we     = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            offset[i] = run;
            we[i]     = (lanes[i] != MOVE_W'(NO_MOVE));
            run       = run + NZ_W'(we[i]);
        end
        nz = run;
    end

endmodule

// File: rtl/move_compactor.sv
// Packs the non-empty codes of each four-lane move beat, in lane order, into a
// first-word-fall-through FIFO and reports the per-batch count of moves accepted.
module move_compactor
    import chess_move_pkg::*;
#(
    parameter int MOVE_W = chess_move_pkg::MOVE_W,
    parameter int LANES  = chess_move_pkg::LANES,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [MOVE_W-1:0] in0,
    input  logic [MOVE_W-1:0] in1,
    input  logic [MOVE_W-1:0] in2,
    input  logic [MOVE_W-1:0] in3,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              pop,
    output logic [MOVE_W-1:0] out_move,
    output logic              out_valid,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  batch_count,
    output logic              batch_done,
    output logic              drop_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int NZ_W  = $clog2(LANES + 1);

    logic [LANES-1:0][MOVE_W-1:0] lanes;
    logic [NZ_W-1:0]              nz;
    logic [LANES-1:0][NZ_W-1:0]   offset;
    logic [LANES-1:0]             we;

    logic [MOVE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  acc;
    logic [CNT_W-1:0]  space;
    logic              accept;
    logic              do_pop;
    logic [CNT_W-1:0]  push_n;

    assign lanes = {in3, in2, in1, in0};

    lane_compactor #(
        .MOVE_W (MOVE_W),
        .LANES  (LANES),
        .NZ_W   (NZ_W)
    ) u_lane_compactor (
        .lanes  (lanes),
        .nz     (nz),
        .offset (offset),
        .we     (we)
    );

    always_comb begin
        space     = CNT_W'(DEPTH) - count;
        in_ready  = (space >= CNT_W'(LANES));
        accept    = in_valid & in_ready;
        out_valid = (count != '0);
        do_pop    = pop & out_valid;
        push_n    = accept ? CNT_W'(nz) : '0;
        // Stale storage is masked so the head reads zero whenever the FIFO is empty.
        out_move  = out_valid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (we[i]) begin
                    mem[wr_ptr + PTR_W'(offset[i])] <= lanes[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            acc         <= '0;
            batch_count <= '0;
            batch_done  <= 1'b0;
            drop_err    <= 1'b0;
        end else begin
            count      <= count + push_n - CNT_W'(do_pop);
            batch_done <= accept & in_last;
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(nz);
                if (in_last) begin
                    batch_count <= acc + CNT_W'(nz);
                    acc         <= '0;
                end else begin
                    acc <= acc + CNT_W'(nz);
                end
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (in_valid && !in_ready) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_move_compactor.sv
// Directed bench for move_compactor with hand-computed expectations and a
// small FIFO model for the streaming wrap-around section.
module tb_move_compactor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in0, in1, in2, in3;
    logic       in_last;
    logic       in_ready;
    logic       pop;
    logic [3:0] out_move;
    logic       out_valid;
    logic [4:0] count;
    logic [4:0] batch_count;
    logic       batch_done;
    logic       drop_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    move_compactor #(
        .MOVE_W (4),
        .LANES  (4),
        .DEPTH  (16),
        .CNT_W  (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in0         (in0),
        .in1         (in1),
        .in2         (in2),
        .in3         (in3),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .pop         (pop),
        .out_move    (out_move),
        .out_valid   (out_valid),
        .count       (count),
        .batch_count (batch_count),
        .batch_done  (batch_done),
        .drop_err    (drop_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d, input logic last);
        in0      = a;
        in1      = b;
        in2      = c;
        in3      = d;
        in_last  = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        logic [3:0] exp2 [5];
        logic [3:0] q [$];
        logic [3:0] nextv;
        int         pushed;
        int         cyc;
        int         mcnt;
        logic       rdy;
        logic       popping;
        logic       pushing;

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; pop = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_move", out_move, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_batch_count", batch_count, 0);
        chk("rst_batch_done", batch_done, 0);
        chk("rst_drop_err", drop_err, 0);
        rst = 1'b0;
        tick();

        // Pop on empty
        pop = 1'b1;
        tick();
        tick();
        pop = 1'b0;
        chk("empty_pop_count", count, 0);
        chk("empty_pop_valid", out_valid, 0);
        chk("empty_pop_drop", drop_err, 0);
        chk("empty_pop_done", batch_done, 0);
        chk("empty_pop_ready", in_ready, 1);

        // Single beat batch {3,0,5,0}
        beat(4'd3, 4'd0, 4'd5, 4'd0, 1'b1);
        chk("t1_count", count, 2);
        chk("t1_head", out_move, 3);
        chk("t1_done", batch_done, 1);
        chk("t1_bcount", batch_count, 2);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("t1_done_pulse", batch_done, 0);
        chk("t1_head2", out_move, 5);
        chk("t1_count2", count, 1);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("t1_empty", out_valid, 0);

        // Two-beat batch
        beat(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        chk("t2_no_done", batch_done, 0);
        beat(4'd0, 4'd0, 4'd0, 4'd9, 1'b1);
        chk("t2_bcount", batch_count, 5);
        chk("t2_done", batch_done, 1);
        chk("t2_count", count, 5);
        exp2[0] = 4'd1; exp2[1] = 4'd2; exp2[2] = 4'd3; exp2[3] = 4'd4; exp2[4] = 4'd9;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_pop%0d", i), out_move, exp2[i]);
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        chk("t2_empty", out_valid, 0);

        // Fill to 13, overflow offer, pop to admit
        beat(4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
        beat(4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
        beat(4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
        beat(4'd2, 4'd0, 4'd0, 4'd0, 1'b0);
        chk("t3_count13", count, 13);
        chk("t3_not_ready", in_ready, 0);
        chk("t3_no_drop_yet", drop_err, 0);
        in0 = 4'd5; in1 = 4'd6; in2 = 4'd7; in3 = 4'd8; in_valid = 1'b1;
        tick();
        chk("t3_rejected", count, 13);
        chk("t3_drop", drop_err, 1);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("t3_count12", count, 12);
        chk("t3_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t3_count16", count, 16);
        chk("t3_full_ready", in_ready, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_drain%0d", i), out_move,
                (i < 11) ? 1 : (i == 11) ? 2 : i - 7);
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        chk("t3_drained", out_valid, 0);
        chk("t3_drop_sticky", drop_err, 1);

        // Streaming with a pop every cycle across pointer wrap
        pushed = 0;
        cyc    = 0;
        mcnt   = 0;
        nextv  = 4'd1;
        pop    = 1'b1;
        while ((pushed < 40 || mcnt > 0) && cyc < 300) begin
            chk("wr_count", count, mcnt);
            chk("wr_bound", (count <= 16), 1);
            if (mcnt > 0) chk("wr_head", out_move, q[0]);
            rdy = ((16 - mcnt) >= 4);
            chk("wr_ready", in_ready, rdy);
            pushing = (pushed < 40) && rdy;
            popping = (mcnt > 0);
            if (pushing) begin
                in0 = nextv;
                in1 = (nextv == 4'd15) ? 4'd1 : nextv + 4'd1;
                in2 = (in1 == 4'd15) ? 4'd1 : in1 + 4'd1;
                in3 = (in2 == 4'd15) ? 4'd1 : in2 + 4'd1;
                nextv = (in3 == 4'd15) ? 4'd1 : in3 + 4'd1;
            end
            in_valid = pushing;
            tick();
            if (popping) void'(q.pop_front());
            if (pushing) begin
                q.push_back(in0); q.push_back(in1); q.push_back(in2); q.push_back(in3);
                pushed += 4;
            end
            mcnt = q.size();
            cyc++;
        end
        in_valid = 1'b0;
        pop      = 1'b0;
        chk("wr_finished", (cyc < 300), 1);
        chk("wr_empty", out_valid, 0);

        // Simultaneous push of 4 and pop at count 8
        beat(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        beat(4'd5, 4'd6, 4'd7, 4'd8, 1'b0);
        chk("t5_count8", count, 8);
        pop = 1'b1;
        beat(4'd9, 4'd10, 4'd11, 4'd12, 1'b0);
        pop = 1'b0;
        chk("t5_count11", count, 11);
        chk("t5_head", out_move, 2);

        // Reset mid-batch
        beat(4'd1, 4'd2, 4'd0, 4'd3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_count", count, 0);
        chk("t7_valid", out_valid, 0);
        chk("t7_drop", drop_err, 0);
        chk("t7_bcount0", batch_count, 0);
        beat(4'd7, 4'd0, 4'd0, 4'd0, 1'b1);
        chk("t7_bcount", batch_count, 1);
        chk("t7_head", out_move, 7);
        chk("t7_done", batch_done, 1);
        chk("t7_count1", count, 1);
        tick();
        chk("t7_done_off", batch_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
